shifter_seq: RTL and testbench

SHIFTER_SEQ -- requirements
Module: shifter_seq

---
 rtl/shifter_seq.sv | 154 +++++++++++++++
 tb/tb_shifter_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_seq.sv
// shifter_seq: sequential 16-bit rotate/shift unit handling one request at a time.
// Optional macro SHIFTER_SEQ_FAST8_EN adds 8-bit steps while the remaining count is >= 8.
module shifter_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in,
    input  logic [1:0]  op,
    input  logic [3:0]  amt,
    output logic [15:0] out,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_ROTL = 2'b00;
    localparam logic [1:0] OP_SHL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_SRL  = 2'b11;

    state_t      state_q, state_d;
    logic [15:0] work_q, work_d;
    logic [1:0]  op_q, op_d;
    logic [3:0]  count_q, count_d;
    logic [15:0] out_q, out_d;
    logic        out_valid_q, out_valid_d;

    logic [15:0] step_s;
    logic [3:0]  count_step_s;

    function automatic logic [15:0] step1(input logic [15:0] r, input logic [1:0] o);
        logic [15:0] res;
        case (o)
            OP_ROTL: res = {r[14:0], r[15]};
            OP_SHL:  res = {r[14:0], 1'b0};
            OP_SRA:  res = {r[15], r[15:1]};
            OP_SRL:  res = {1'b0, r[15:1]};
            default: res = r;
        endcase
        return res;
    endfunction

`ifdef SHIFTER_SEQ_FAST8_EN
    function automatic logic [15:0] step8(input logic [15:0] r, input logic [1:0] o);
        logic [15:0] res;
        case (o)
            OP_ROTL: res = {r[7:0], r[15:8]};
            OP_SHL:  res = {r[7:0], 8'h00};
            OP_SRA:  res = {{8{r[15]}}, r[15:8]};
            OP_SRL:  res = {8'h00, r[15:8]};
            default: res = r;
        endcase
        return res;
    endfunction
`endif

    // Select the step applied this cycle and the count it leaves behind.
    always_comb begin
`ifdef SHIFTER_SEQ_FAST8_EN
        if (count_q >= 4'd8) begin
            step_s       = step8(work_q, op_q);
            count_step_s = count_q - 4'd8;
        end else begin
            step_s       = step1(work_q, op_q);
            count_step_s = count_q - 4'd1;
        end
`else
        step_s       = step1(work_q, op_q);
        count_step_s = count_q - 4'd1;
`endif
    end

    // Next-state and datapath update for the accept/shift/handshake sequence.
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        op_d        = op_q;
        count_d     = count_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in;
                    op_d    = op;
                    count_d = amt;
                    if (amt == 4'd0) begin
                        state_d     = DONE;
                        out_d       = in;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = SHIFT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                work_d  = step_s;
                count_d = count_step_s;
                // The final step lands in out on the same edge the count hits zero.
                if (count_step_s == 4'd0) begin
                    state_d     = DONE;
                    out_d       = step_s;
                    out_valid_d = 1'b1;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and result registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            work_q      <= 16'h0000;
            op_q        <= 2'b00;
            count_q     <= 4'd0;
            out_q       <= 16'h0000;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            op_q        <= op_d;
            count_q     <= count_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_shifter_seq.sv
// Self-checking bench for shifter_seq: arithmetic reference model, per-cycle compare,
// directed literal vectors and randomized requests.
module tb_shifter_seq;

`ifdef SHIFTER_SEQ_FAST8_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0000;
    logic [1:0]  op_i = 2'b00;
    logic [3:0]  amt_i = 4'd0;
    logic [15:0] out_w;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    shifter_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_data),
        .op        (op_i),
        .amt       (amt_i),
        .out       (out_w),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Reference result from plain arithmetic on the whole operand.
    function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [1:0] o,
                                              input logic [3:0] a);
        logic [31:0] dbl;
        logic [15:0] s;
        case (o)
            2'b00: begin dbl = {d, d} << a; s = dbl[31:16]; end
            2'b01: s = d << a;
            2'b10: s = $signed(d) >>> a;
            default: s = d >> a;
        endcase
        return s;
    endfunction

    function automatic int ref_lat(input logic [3:0] a);
        int ai;
        ai = int'(a);
        if (FAST && ai >= 8) return ai - 7;
        return ai;
    endfunction

    // Model: phase 0 idle, 1 busy for a number of edges, 2 holding a result.
    int          m_phase = 0;
    int          m_wait  = 0;
    logic [15:0] m_res   = 16'h0000;
    logic [15:0] m_out   = 16'h0000;
    logic        m_valid = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_wait  <= 0;
            m_res   <= 16'h0000;
            m_out   <= 16'h0000;
            m_valid <= 1'b0;
        end else begin
            if (m_phase == 0) begin
                if (in_valid) begin
                    if (ref_lat(amt_i) == 0) begin
                        m_phase <= 2;
                        m_out   <= ref_shift(in_data, op_i, amt_i);
                        m_valid <= 1'b1;
                    end else begin
                        m_phase <= 1;
                        m_wait  <= ref_lat(amt_i);
                        m_res   <= ref_shift(in_data, op_i, amt_i);
                    end
                end
            end else if (m_phase == 1) begin
                if (m_wait == 1) begin
                    m_phase <= 2;
                    m_out   <= m_res;
                    m_valid <= 1'b1;
                end else begin
                    m_wait <= m_wait - 1;
                end
            end else begin
                if (out_ready) begin
                    m_phase <= 0;
                    m_valid <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if ($time > 2) begin
            chk("cyc_in_ready", {31'd0, in_ready}, {31'd0, (m_phase == 0)});
            chk("cyc_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            chk("cyc_out", {16'd0, out_w}, {16'd0, m_out});
        end
    end

    task automatic scramble();
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 16'($urandom);
        op_i     = 2'($urandom_range(0, 3));
        amt_i    = 4'($urandom_range(0, 15));
    endtask

    task automatic do_req(input string name, input logic [15:0] d, input logic [1:0] o,
                          input logic [3:0] a, input int hold,
                          input logic [15:0] exp_o, input int exp_lat);
        int cyc;
        chk({name, "_ready_pre"}, {31'd0, in_ready}, 32'd1);
        in_data = d; op_i = o; amt_i = a; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        scramble();
        chk({name, "_ready_busy"}, {31'd0, in_ready}, 32'd0);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            scramble();
            cyc++;
        end
        chk({name, "_latency"}, cyc, exp_lat);
        chk({name, "_result"}, {16'd0, out_w}, {16'd0, exp_o});
        repeat (hold) begin
            @(posedge clk); #1;
            scramble();
        end
        chk({name, "_hold_out"}, {16'd0, out_w}, {16'd0, exp_o});
        chk({name, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
        chk({name, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({name, "_post_valid"}, {31'd0, out_valid}, 32'd0);
        chk({name, "_post_ready"}, {31'd0, in_ready}, 32'd1);
        chk({name, "_retain"}, {16'd0, out_w}, {16'd0, exp_o});
    endtask

    initial begin
        logic [15:0] rd;
        logic [1:0]  ro;
        logic [3:0]  ra;

        #1 rst_n = 1'b0;
        #2;
        chk("reset_out", {16'd0, out_w}, 32'h0000);
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        #19 rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Model self-pins against hand-computed values.
        chk("ref_rotl", {16'd0, ref_shift(16'h8001, 2'b00, 4'd4)}, 32'h0018);
        chk("ref_sra", {16'd0, ref_shift(16'h8000, 2'b10, 4'd15)}, 32'hFFFF);
        chk("ref_srl", {16'd0, ref_shift(16'hABCD, 2'b11, 4'd8)}, 32'h00AB);

        do_req("rotl4", 16'h8001, 2'b00, 4'd4, 0, 16'h0018, 4);
        do_req("sra15", 16'h8000, 2'b10, 4'd15, 0, 16'hFFFF, FAST ? 8 : 15);
        do_req("srl8", 16'hABCD, 2'b11, 4'd8, 0, 16'h00AB, FAST ? 1 : 8);
        do_req("rotl8", 16'hABCD, 2'b00, 4'd8, 0, 16'hCDAB, FAST ? 1 : 8);
        do_req("shl0", 16'h1234, 2'b01, 4'd0, 0, 16'h1234, 0);
        do_req("hold5", 16'h00F0, 2'b01, 4'd3, 5, 16'h0780, 3);
        do_req("sra9", 16'h8F00, 2'b10, 4'd9, 2, 16'hFFC7, FAST ? 2 : 9);

        // Reset during the third shift cycle aborts the request.
        in_data = 16'hFFFF; op_i = 2'b01; amt_i = 4'd12; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        chk("abort_out", {16'd0, out_w}, 32'h0000);
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_req("after_rst", 16'hFFFF, 2'b01, 4'd12, 0, 16'hF000, FAST ? 5 : 12);

        for (int i = 0; i < 150; i++) begin
            rd = 16'($urandom);
            ro = 2'($urandom_range(0, 3));
            ra = 4'($urandom_range(0, 15));
            do_req("rand", rd, ro, ra, $urandom_range(0, 3), ref_shift(rd, ro, ra), ref_lat(ra));
        end

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
